// File: rtl/dm_fetch_if.sv
// -----------------------------------------------------------------------------
// dm_fetch_if
//
// Purpose : Bundles every job-control, data-memory and output signal of the
//           dm_fetch row fetcher.  Only clk and rst stay outside the bundle.
//
// Modports:
//   slave  - the fetcher itself.
//            inputs : start, abort, base_addr, mode, dm_rdata, arrange_done
//            outputs: dm_csb, dm_oeb, dm_addr, data_valid, out_data,
//                     position, mode_out, busy, finish, error
//   master - the environment around it (job issuer, data memory and the
//            downstream arranger); directions mirrored.
//
// ADDR_W / DATA_W must match the parameters of the dm_fetch instance that
// the bundle is connected to.
// -----------------------------------------------------------------------------
interface dm_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 3072
);
    // job control
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [1:0]        mode;
    // data memory read port
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_csb;
    logic              dm_oeb;
    logic [ADDR_W-1:0] dm_addr;
    // downstream handshake and row output
    logic              arrange_done;
    logic              data_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        position;
    logic [1:0]        mode_out;
    // status
    logic              busy;
    logic              finish;
    logic              error;

    modport slave (
        input  start, abort, base_addr, mode, dm_rdata, arrange_done,
        output dm_csb, dm_oeb, dm_addr, data_valid, out_data,
               position, mode_out, busy, finish, error
    );

    modport master (
        output start, abort, base_addr, mode, dm_rdata, arrange_done,
        input  dm_csb, dm_oeb, dm_addr, data_valid, out_data,
               position, mode_out, busy, finish, error
    );
endinterface

// File: rtl/dm_fetch.sv
// -----------------------------------------------------------------------------
// dm_fetch
//
// Purpose : Fetches the 16 consecutive data-memory rows of one FFT job
//           (base_addr .. base_addr+15, wrapping modulo 2^ADDR_W).  It
//           presents each row on out_data with a one-cycle data_valid pulse.
//           It then waits for the downstream arranger to report the row as
//           written (arrange_done) before it reads the next row.
//
// Ports   :
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   bus.start      in   job request pulse (ignored while a job is active)
//   bus.abort      in   cancel the current job, return to idle
//   bus.base_addr  in   first DM row of the job
//   bus.mode       in   FFT size code, latched to mode_out at job start
//   bus.dm_rdata   in   DM read data, valid one cycle after the read request
//   bus.arrange_done in downstream row-written pulse
//   bus.dm_csb     out  DM chip select, active-low
//   bus.dm_oeb     out  DM output enable, active-low
//   bus.dm_addr    out  DM read address
//   bus.data_valid out  one-cycle row-valid pulse
//   bus.out_data   out  registered row
//   bus.position   out  row index 0..15 within the job
//   bus.mode_out   out  mode latched for the job
//   bus.busy       out  job active
//   bus.finish     out  one-cycle job-complete pulse
//   bus.error      out  sticky arrange_done timeout flag
//
// Timing  : a start accepted in cycle 0 drives dm_csb low in cycle 1 and
//           data_valid in cycle 3.  arrange_done in cycle k drives dm_csb
//           low again in cycle k+1.
// -----------------------------------------------------------------------------
module dm_fetch #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 3072,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    dm_fetch_if.slave  bus
);

    // Wide enough to hold TIMEOUT itself.  The counter steps past the last
    // value once, on the cycle the FSM leaves WAIT_DONE.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       POS_LAST  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_MEM  = 3'd2,
        S_VALID     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_base;
    logic [3:0]        r_position;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_out_data;
    logic              r_error;
    logic [CNT_W-1:0]  r_tcnt;

    // One-cycle event strobes decoded alongside the next state.
    logic              w_accept;   // start taken in IDLE
    logic              w_advance;  // row done, another row follows
    logic              w_timeout;  // arranger gave up on
    logic              w_capture;  // memory data is on dm_rdata this cycle

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and event decode.  abort takes priority over every other
    // input, including start and arrange_done in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_timeout    = 1'b0;
        w_capture    = 1'b0;

        if (bus.abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_next = S_REQ;
                        w_accept     = 1'b1;
                    end
                end
                S_REQ: begin
                    w_state_next = S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    w_state_next = S_VALID;
                    w_capture    = 1'b1;
                end
                S_VALID: begin
                    w_state_next = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.arrange_done) begin
                        if (r_position == POS_LAST) begin
                            w_state_next = S_FINISH;
                        end else begin
                            w_state_next = S_REQ;
                            w_advance    = 1'b1;
                        end
                    end else if (r_tcnt == TCNT_LAST) begin
                        w_state_next = S_IDLE;
                        w_timeout    = 1'b1;
                    end
                end
                S_FINISH: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Job context: base address, mode and row index.  These change only when
    // a job is accepted or a row is completed, so dm_addr and position stay
    // stable for the whole REQ..WAIT_DONE span of a row.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_mode     <= 2'b00;
            r_position <= 4'd0;
        end else if (w_accept) begin
            r_base     <= bus.base_addr;
            r_mode     <= bus.mode;
            r_position <= 4'd0;
        end else if (w_advance) begin
            r_position <= r_position + 4'd1;
        end
    end

    // Row capture at the closing edge of WAIT_MEM.  The row is then held
    // until the next row is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_capture) begin
            r_out_data <= bus.dm_rdata;
        end
    end

    // Timeout counter.  It is held at zero outside WAIT_DONE, so it restarts
    // on every entry into WAIT_DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state == S_WAIT_DONE) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end

    // The error flag stays set through IDLE so software can read it.  Only
    // the next accepted job, or reset, clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from the state register or taken straight from
    // registers, so none of them depends combinationally on an input.
    // -------------------------------------------------------------------------
    assign bus.dm_csb     = (r_state != S_REQ);
    assign bus.dm_oeb     = !((r_state == S_REQ) || (r_state == S_WAIT_MEM));
    // The sum wraps silently modulo 2^ADDR_W.
    assign bus.dm_addr    = r_base + ADDR_W'(r_position);
    assign bus.data_valid = (r_state == S_VALID);
    assign bus.out_data   = r_out_data;
    assign bus.position   = r_position;
    assign bus.mode_out   = r_mode;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.finish     = (r_state == S_FINISH);
    assign bus.error      = r_error;

endmodule

// File: doc/dm_fetch.md
DM_FETCH -- requirements
Module: dm_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 3072, data-memory row width (8 streams x 16 points x 24 bit).
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum WAIT_DONE cycles before error.
REQ-004 SHALL have ports (clock and reset first): clk in 1 system clock; rst in 1 reset; start in 1 job request pulse; abort in 1 synchronous job cancel; base_addr in ADDR_W first DM row of job; mode in 2 FFT size (00 fft16, 01 fft8, 10 fft4, 11 fft2); dm_rdata in DATA_W DM read data; arrange_done in 1 downstream row-written pulse; dm_csb out 1 DM chip select, active-low; dm_oeb out 1 DM output enable, active-low; dm_addr out ADDR_W DM read address; data_valid out 1 row-valid pulse; out_data out DATA_W registered row; position out 4 row index; mode_out out 2 latched mode; busy out 1 job active; finish out 1 job-complete pulse; error out 1 sticky timeout flag.
REQ-005 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-006 SHALL implement states IDLE, REQ, WAIT_MEM, VALID, WAIT_DONE, FINISH; all outputs registered or decoded from state registers only.
REQ-007 IDLE: start=1 and abort=0 -> REQ; latch base_addr, mode into mode_out; position <= 0; clear error.
REQ-008 start while not IDLE SHALL be ignored.
REQ-009 REQ (1 cycle): dm_csb=0, dm_oeb=0, dm_addr = base_latched + position (mod 2^ADDR_W, wrap silently); -> WAIT_MEM.
REQ-010 WAIT_MEM (1 cycle): dm_csb=1, dm_oeb=0; at its closing edge out_data <= dm_rdata; -> VALID.
REQ-011 VALID (1 cycle): data_valid=1; -> WAIT_DONE; out_data held until next WAIT_MEM capture.
REQ-012 WAIT_DONE: arrange_done=1 with position<15 -> position+1, -> REQ; with position=15 -> FINISH, position held at 15.
REQ-013 WAIT_DONE timeout: cycle counter reset on entry; if TIMEOUT cycles elapse without arrange_done -> error<=1, -> IDLE, no finish.
REQ-014 FINISH (1 cycle): finish=1; -> IDLE.
REQ-015 position SHALL change only on REQ-012 transitions or start acceptance; stable through REQ..WAIT_DONE of each row.
REQ-016 arrange_done outside WAIT_DONE SHALL be ignored.
REQ-017 busy=1 in every state except IDLE.
REQ-018 abort=1 in any state: next state IDLE, no finish, data_valid not asserted next cycle; abort beats start and arrange_done in the same cycle.
REQ-019 Latency: start in cycle 0 -> dm_csb low cycle 1 -> data_valid cycle 3; arrange_done in cycle k -> next dm_csb low cycle k+1.
REQ-020 Job issues exactly 16 data_valid pulses, positions 0..15, regardless of mode; mode_out constant for the job.

Reset
REQ-021 rst=1 SHALL force immediately: state IDLE, dm_csb=1, dm_oeb=1, dm_addr=0, data_valid=0, out_data=0, position=0, mode_out=0, busy=0, finish=0, error=0, timeout counter=0.
REQ-022 rst mid-job SHALL abandon the job with no finish pulse; first start after release SHALL run normally.

Verification
REQ-023 base_addr=0x10, mode=00, start; DM model 1-cycle latency, arrange_done 5 cycles after each data_valid -> dm_addr 0x10..0x1F in order, 16 data_valid, out_data matches rows, finish once, error=0.
REQ-024 base_addr=0xF8 -> dm_addr sequence 0xF8..0xFF then 0x00..0x07.
REQ-025 arrange_done withheld on row 3 -> error=1 TIMEOUT cycles after WAIT_DONE entry, busy=0, no finish; next start clears error.
REQ-026 abort asserted with arrange_done on row 7 -> IDLE next cycle, position stays 7, no further DM access, no finish.
REQ-027 start pulsed mid-job and arrange_done pulsed in IDLE -> no effect; job completes with exactly 16 rows.
REQ-028 rst asserted during WAIT_MEM -> all outputs at REQ-021 values asynchronously; restart with mode=10 -> mode_out=10, full 16-row job.
